alu_seq_64: RTL and testbench

- Multi-cycle 64-bit Y86-64 execute-stage ALU with a start/done handshake and registered condition codes.
- Computes OPq (addq/subq/andq/xorq) by processing the operands 16 bits per cycle, with the carry held in a register between chunks.
- subq is built as valB + ~valA + 1 on the same chunk datapath.
- Sits between decode (valA/valB/ifun) and the CC register consumer (conditional move/jump logic).

---
 rtl/alu_seq_defs.sv | 33 +++
 rtl/chunk_addsub.sv | 56 +++++
 rtl/alu_seq_64.sv | 224 ++++++++++++++++++++++
 tb/tb_alu_seq_64.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_defs.sv
// ============================================================================
// Module   : alu_seq_defs (package)
// Purpose  : Shared constants for the multi-cycle Y86-64 execute ALU:
//            ifun operation codes, FSM state encodings and default widths.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_seq_defs;

  // Default datapath geometry
  localparam int N_DEF     = 64;
  localparam int CHUNK_DEF = 16;

  // ifun operation codes (OPq group)
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_XOR = 4'd3;

  // Controller states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Only the four OPq codes are defined; everything else raises err.
  function automatic logic ifun_legal(input logic [3:0] f);
    return (f <= ALU_XOR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/chunk_addsub.sv
// ============================================================================
// Module   : chunk_addsub
// Purpose  : CHUNK-bit ripple adder built from gate-level full adders.
//            Operand a is optionally inverted (inv_a) so the same cell does
//            b + a + cin and b + ~a + cin (subtraction with cin = 1).
// Ports    : a, b    [CHUNK-1:0] in   operands
//            inv_a               in   invert a before adding
//            cin                 in   carry in
//            sum     [CHUNK-1:0] out  b + (inv_a ? ~a : a) + cin
//            cout                out  carry out of the top bit
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module chunk_addsub #(
  parameter int CHUNK = 16
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             inv_a,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  wire [CHUNK:0]   w_c;
  wire [CHUNK-1:0] w_sum;
  wire             w_ninv;

  assign w_c[0] = cin;
  not u_ninv (w_ninv, inv_a);

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    wire w_na, w_s0, w_s1, w_ai;
    wire w_p, w_g, w_t;

    // Operand select: a[i] when inv_a=0, ~a[i] when inv_a=1.
    not u_na  (w_na, a[i]);
    and u_s0  (w_s0, a[i], w_ninv);
    and u_s1  (w_s1, w_na, inv_a);
    or  u_sel (w_ai, w_s0, w_s1);

    // Full adder: propagate/generate form.
    xor u_p   (w_p, w_ai, b[i]);
    xor u_s   (w_sum[i], w_p, w_c[i]);
    and u_g   (w_g, w_ai, b[i]);
    and u_t   (w_t, w_p, w_c[i]);
    or  u_co  (w_c[i+1], w_g, w_t);
  end

  assign sum  = w_sum;
  assign cout = w_c[CHUNK];

endmodule

`default_nettype wire

// File: rtl/alu_seq_64.sv
// ============================================================================
// Module   : alu_seq_64
// Purpose  : Multi-cycle Y86-64 execute-stage ALU. Processes addq/subq/andq/
//            xorq CHUNK bits per cycle (LSB chunk first) with the carry held
//            in a register between chunks; registers the result and the
//            zf/sf/of condition codes when the last chunk completes.
// Ports    : clk               in   rising-edge clock
//            rst_n             in   asynchronous active-low reset
//            start             in   operation request (sampled when ready)
//            ifun    [3:0]     in   0 addq, 1 subq, 2 andq, 3 xorq
//            val_a   [N-1:0]   in   operand A
//            val_b   [N-1:0]   in   operand B
//            busy              out  high while chunks are being processed
//            done              out  one-cycle pulse: val_e/flags valid
//            val_e   [N-1:0]   out  B+A, B-A, B&A or B^A
//            zf, sf, of        out  condition codes
//            err               out  previous ifun was illegal
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_seq_64
  import alu_seq_defs::*;
#(
  parameter int N     = N_DEF,
  parameter int CHUNK = CHUNK_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [3:0]   ifun,
  input  logic [N-1:0] val_a,
  input  logic [N-1:0] val_b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] val_e,
  output logic         zf,
  output logic         sf,
  output logic         of,
  output logic         err
);

  localparam int              NCH      = N / CHUNK;
  localparam int              IDXW     = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCH - 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]      state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [3:0]      ifun_q, ifun_d;
  logic [N-1:0]    a_q, a_d;       // shifts right one chunk per RUN cycle
  logic [N-1:0]    b_q, b_d;
  logic            a_sgn_q, a_sgn_d; // operand sign bits kept for overflow
  logic            b_sgn_q, b_sgn_d;
  logic [N-1:0]    res_q, res_d;   // partial-result shift register
  logic [N-1:0]    val_e_q, val_e_d;
  logic            zf_q, zf_d;
  logic            sf_q, sf_d;
  logic            of_q, of_d;
  logic            err_q, err_d;

  // --------------------------------------------------------------------------
  // Chunk datapath: always operates on the low chunk of the shifting operands
  // --------------------------------------------------------------------------
  logic [CHUNK-1:0] w_a_chunk, w_b_chunk, w_sum, w_chunk_res;
  logic             w_cout, w_sub;
  logic [N-1:0]     w_res_full;
  logic             w_of;

  assign w_a_chunk = a_q[CHUNK-1:0];
  assign w_b_chunk = b_q[CHUNK-1:0];
  assign w_sub     = (ifun_q == ALU_SUB);

  chunk_addsub #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .a     (w_a_chunk),
    .b     (w_b_chunk),
    .inv_a (w_sub),
    .cin   (carry_q),
    .sum   (w_sum),
    .cout  (w_cout)
  );

  always_comb begin
    w_chunk_res = '0;
    case (ifun_q)
      ALU_ADD, ALU_SUB: w_chunk_res = w_sum;
      ALU_AND:          w_chunk_res = w_b_chunk & w_a_chunk;
      ALU_XOR:          w_chunk_res = w_b_chunk ^ w_a_chunk;
      default:          w_chunk_res = '0;
    endcase
  end

  // New chunk enters at the top; after NCH shifts chunk 0 sits at the bottom.
  assign w_res_full = {w_chunk_res, res_q[N-1:CHUNK]};

  always_comb begin
    w_of = 1'b0;
    case (ifun_q)
      ALU_ADD: w_of = (a_sgn_q == b_sgn_q) && (w_res_full[N-1] != b_sgn_q);
      ALU_SUB: w_of = (a_sgn_q != b_sgn_q) && (w_res_full[N-1] != b_sgn_q);
      default: w_of = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    ifun_d  = ifun_q;
    a_d     = a_q;
    b_d     = b_q;
    a_sgn_d = a_sgn_q;
    b_sgn_d = b_sgn_q;
    res_d   = res_q;
    val_e_d = val_e_q;
    zf_d    = zf_q;
    sf_d    = sf_q;
    of_d    = of_q;
    err_d   = err_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          idx_d   = '0;
          carry_d = (ifun == ALU_SUB);  // +1 completes the two's complement
          ifun_d  = ifun;
          a_d     = val_a;
          b_d     = val_b;
          a_sgn_d = val_a[N-1];
          b_sgn_d = val_b[N-1];
          err_d   = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        carry_d = w_cout;
        idx_d   = idx_q + 1'b1;
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        res_d   = w_res_full;
        if (idx_q == LAST_IDX) begin
          // Carry out of the top chunk is dropped: mod 2^N arithmetic.
          state_d = ST_DONE;
          idx_d   = '0;
          if (ifun_legal(ifun_q)) begin
            val_e_d = w_res_full;
            zf_d    = (w_res_full == '0);
            sf_d    = w_res_full[N-1];
            of_d    = w_of;
            err_d   = 1'b0;
          end else begin
            // Illegal op: zero result, condition codes left untouched.
            val_e_d = '0;
            err_d   = 1'b1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      ifun_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      a_sgn_q <= 1'b0;
      b_sgn_q <= 1'b0;
      res_q   <= '0;
      val_e_q <= '0;
      zf_q    <= 1'b0;
      sf_q    <= 1'b0;
      of_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      ifun_q  <= ifun_d;
      a_q     <= a_d;
      b_q     <= b_d;
      a_sgn_q <= a_sgn_d;
      b_sgn_q <= b_sgn_d;
      res_q   <= res_d;
      val_e_q <= val_e_d;
      zf_q    <= zf_d;
      sf_q    <= sf_d;
      of_q    <= of_d;
      err_q   <= err_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign busy  = (state_q == ST_RUN);
  assign done  = (state_q == ST_DONE);
  assign val_e = val_e_q;
  assign zf    = zf_q;
  assign sf    = sf_q;
  assign of    = of_q;
  assign err   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_seq_64.sv
// ============================================================================
// Module   : tb_alu_seq_64
// Purpose  : Self-checking bench for alu_seq_64. Expected results come from a
//            behavioural 64-bit model and are queued when an operation is
//            issued, then popped and compared when done is seen.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_seq_64;

  typedef struct {
    logic [63:0] v;
    logic        zf;
    logic        sf;
    logic        of;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  ifun;
  logic [63:0] val_a, val_b;
  logic        busy, done, zf, sf, of, err;
  logic [63:0] val_e;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  logic m_zf = 1'b0, m_sf = 1'b0, m_of = 1'b0;

  always #5 clk = ~clk;

  alu_seq_64 #(.N(64), .CHUNK(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .ifun  (ifun),
    .val_a (val_a),
    .val_b (val_b),
    .busy  (busy),
    .done  (done),
    .val_e (val_e),
    .zf    (zf),
    .sf    (sf),
    .of    (of),
    .err   (err)
  );

  // Behavioural reference; illegal codes keep the model's previous flags.
  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                 input logic [3:0] f);
    exp_t e;
    logic [63:0] r;
    e.err = 1'b0;
    e.of  = 1'b0;
    case (f)
      4'd0: begin r = b + a; e.of = (a[63] == b[63]) && (r[63] != b[63]); end
      4'd1: begin r = b - a; e.of = (a[63] != b[63]) && (r[63] != b[63]); end
      4'd2: r = b & a;
      4'd3: r = b ^ a;
      default: r = '0;
    endcase
    e.v = r;
    if (f > 4'd3) begin
      e.err = 1'b1;
      e.zf  = m_zf;
      e.sf  = m_sf;
      e.of  = m_of;
    end else begin
      e.zf = (r == 64'd0);
      e.sf = r[63];
    end
    return e;
  endfunction

  task automatic drive_start(input logic [63:0] a, input logic [63:0] b,
                             input logic [3:0] f);
    exp_t e;
    val_a = a;
    val_b = b;
    ifun  = f;
    start = 1'b1;
    e = model(a, b, f);
    sb_q.push_back(e);
    m_zf = e.zf;
    m_sf = e.sf;
    m_of = e.of;
  endtask

  // Issue one op at a negedge, then step negedges until done (bounded).
  task automatic run_op(input logic [63:0] a, input logic [63:0] b,
                        input logic [3:0] f, output int cyc, output int bc,
                        output bit to);
    cyc = 0;
    bc  = 0;
    to  = 1'b0;
    @(negedge clk);
    drive_start(a, b, f);
    while (1) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (busy) bc++;
      if (done) break;
      if (cyc >= 20) begin
        to = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    ifun  = 4'd0;
    val_a = '0;
    val_b = '0;
    @(negedge clk);
    checks++;
    if ({busy, done, err, zf, sf, of, val_e} !== 70'd0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b err=%b zf=%b sf=%b of=%b val_e=%h, want all 0",
               busy, done, err, zf, sf, of, val_e);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL idle_after_reset: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_add;
    int cyc, bc;
    bit to;
    exp_t e;
    run_op(64'd5, 64'd3, 4'd0, cyc, bc, to);
    e = sb_q.pop_front();
    checks++;
    if (to || cyc !== 5) begin
      errors++;
      $display("FAIL add_latency: got %0d cycles (timeout=%0d), want 5", cyc, to);
    end
    checks++;
    if (bc !== 4) begin
      errors++;
      $display("FAIL add_busy_cycles: got %0d, want 4", bc);
    end
    checks++;
    if ({val_e, zf, sf, of, err} !== {e.v, e.zf, e.sf, e.of, e.err}) begin
      errors++;
      $display("FAIL add_result: got %h z%b s%b o%b e%b, want %h z%b s%b o%b e%b",
               val_e, zf, sf, of, err, e.v, e.zf, e.sf, e.of, e.err);
    end
    checks++;
    if (val_e !== 64'h8) begin
      errors++;
      $display("FAIL add_value: got %h, want 0000000000000008", val_e);
    end
  endtask

  task automatic test_sub;
    int cyc, bc;
    bit to;
    exp_t e;
    logic [63:0] va[2] = '{64'd1, 64'd5};
    logic [63:0] vb[2] = '{64'h0000_0000_0001_0000, 64'd5};
    for (int i = 0; i < 2; i++) begin
      run_op(va[i], vb[i], 4'd1, cyc, bc, to);
      e = sb_q.pop_front();
      checks++;
      if (to || {val_e, zf, sf, of, err} !== {e.v, e.zf, e.sf, e.of, e.err}) begin
        errors++;
        $display("FAIL sub_%0d: got %h z%b s%b o%b e%b (timeout=%0d), want %h z%b s%b o%b e%b",
                 i, val_e, zf, sf, of, err, to, e.v, e.zf, e.sf, e.of, e.err);
      end
    end
  endtask

  task automatic test_overflow;
    int cyc, bc;
    bit to;
    exp_t e;
    logic [63:0] va[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1};
    logic [63:0] vb[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000};
    logic [3:0]  vf[2] = '{4'd0, 4'd1};
    for (int i = 0; i < 2; i++) begin
      run_op(va[i], vb[i], vf[i], cyc, bc, to);
      e = sb_q.pop_front();
      checks++;
      if (to || {val_e, zf, sf, of, err} !== {e.v, e.zf, e.sf, e.of, e.err}) begin
        errors++;
        $display("FAIL overflow_%0d: got %h z%b s%b o%b e%b (timeout=%0d), want %h z%b s%b o%b e%b",
                 i, val_e, zf, sf, of, err, to, e.v, e.zf, e.sf, e.of, e.err);
      end
    end
  endtask

  task automatic test_logic;
    int cyc, bc;
    bit to;
    exp_t e;
    logic [63:0] r;
    r = {$urandom, $urandom};
    run_op(64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 4'd2, cyc, bc, to);
    e = sb_q.pop_front();
    checks++;
    if (to || {val_e, zf, sf, of, err} !== {e.v, e.zf, e.sf, e.of, e.err}) begin
      errors++;
      $display("FAIL andq: got %h z%b s%b o%b e%b, want %h z%b s%b o%b e%b",
               val_e, zf, sf, of, err, e.v, e.zf, e.sf, e.of, e.err);
    end
    run_op(r, r, 4'd3, cyc, bc, to);
    e = sb_q.pop_front();
    checks++;
    if (to || {val_e, zf, sf, of, err} !== {e.v, e.zf, e.sf, e.of, e.err}) begin
      errors++;
      $display("FAIL xorq_self: got %h z%b s%b o%b e%b, want %h z%b s%b o%b e%b",
               val_e, zf, sf, of, err, e.v, e.zf, e.sf, e.of, e.err);
    end
  endtask

  task automatic test_illegal;
    int cyc, bc;
    bit to;
    exp_t e;
    // Prior op leaves sf=1, of=1 so "flags unchanged" is observable.
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 4'd0, cyc, bc, to);
    void'(sb_q.pop_front());
    run_op(64'h1234, 64'h5678, 4'd7, cyc, bc, to);
    e = sb_q.pop_front();
    checks++;
    if (to || cyc !== 5 || {val_e, zf, sf, of, err} !== {e.v, e.zf, e.sf, e.of, e.err}) begin
      errors++;
      $display("FAIL illegal_ifun: got %h z%b s%b o%b e%b cyc=%0d, want %h z%b s%b o%b e%b cyc=5",
               val_e, zf, sf, of, err, cyc, e.v, e.zf, e.sf, e.of, e.err);
    end
    // err must clear as soon as the next start is accepted.
    @(negedge clk);
    drive_start(64'd2, 64'd9, 4'd0);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({err, busy} !== 2'b01) begin
      errors++;
      $display("FAIL err_clear: got err=%b busy=%b, want err=0 busy=1", err, busy);
    end
    cyc = 0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    e = sb_q.pop_front();
    checks++;
    if (!done || {val_e, zf, sf, of, err} !== {e.v, e.zf, e.sf, e.of, e.err}) begin
      errors++;
      $display("FAIL after_illegal: got done=%b %h z%b s%b o%b e%b, want %h z%b s%b o%b e%b",
               done, val_e, zf, sf, of, err, e.v, e.zf, e.sf, e.of, e.err);
    end
  endtask

  task automatic test_hold_start;
    int ndone = 0;
    exp_t e;
    @(negedge clk);
    drive_start(64'd10, 64'd20, 4'd0);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 4) start = 1'b0;  // drop before the DONE edge
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          e = sb_q.pop_front();
          checks++;
          if (c !== 5 || {val_e, err} !== {e.v, e.err}) begin
            errors++;
            $display("FAIL hold_result: got %h err=%b at cycle %0d, want %h err=%b at cycle 5",
                     val_e, err, c, e.v, e.err);
          end
        end
      end
    end
    checks++;
    if (ndone !== 1) begin
      errors++;
      $display("FAIL hold_start_dones: got %0d done pulses, want 1", ndone);
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] va[3] = '{64'h1111, 64'hFFFF_FFFF_FFFF_FFFF, 64'h00FF_00FF_00FF_00FF};
    logic [63:0] vb[3] = '{64'h2222, 64'd1, 64'h0F0F_0F0F_0F0F_0F0F};
    logic [3:0]  vf[3] = '{4'd0, 4'd0, 4'd3};
    int ndone = 0, last = 0, c = 0;
    exp_t e;
    @(negedge clk);
    drive_start(va[0], vb[0], vf[0]);
    while (ndone < 3 && c < 40) begin
      @(negedge clk);
      start = 1'b0;
      c++;
      if (done) begin
        e = sb_q.pop_front();
        checks++;
        if ({val_e, zf, sf, of, err} !== {e.v, e.zf, e.sf, e.of, e.err}) begin
          errors++;
          $display("FAIL b2b_result_%0d: got %h z%b s%b o%b e%b, want %h z%b s%b o%b e%b",
                   ndone, val_e, zf, sf, of, err, e.v, e.zf, e.sf, e.of, e.err);
        end
        if (ndone > 0) begin
          checks++;
          if (c - last !== 5) begin
            errors++;
            $display("FAIL b2b_spacing_%0d: got %0d cycles, want 5", ndone, c - last);
          end
        end
        last = c;
        ndone++;
        if (ndone < 3) drive_start(va[ndone], vb[ndone], vf[ndone]);
      end
    end
    checks++;
    if (ndone !== 3) begin
      errors++;
      $display("FAIL b2b_timeout: got %0d dones, want 3", ndone);
    end
  endtask

  task automatic test_reset_midrun;
    int ndone = 0, cyc, bc;
    bit to;
    exp_t e;
    @(negedge clk);
    drive_start(64'hAAAA_BBBB_CCCC_DDDD, 64'h1111_2222_3333_4444, 4'd1);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);  // three edges in: working on chunk index 2
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midrun_busy: got busy=%b, want 1", busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, err, zf, sf, of, val_e} !== 70'd0) begin
      errors++;
      $display("FAIL async_reset: got busy=%b done=%b err=%b zf=%b sf=%b of=%b val_e=%h, want all 0",
               busy, done, err, zf, sf, of, val_e);
    end
    void'(sb_q.pop_front());  // aborted op produces nothing
    m_zf = 1'b0;
    m_sf = 1'b0;
    m_of = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    checks++;
    if (ndone !== 0) begin
      errors++;
      $display("FAIL spurious_done: got %0d done pulses after reset, want 0", ndone);
    end
    run_op(64'd7, 64'd100, 4'd1, cyc, bc, to);
    e = sb_q.pop_front();
    checks++;
    if (to || {val_e, zf, sf, of, err} !== {e.v, e.zf, e.sf, e.of, e.err}) begin
      errors++;
      $display("FAIL post_reset_op: got %h z%b s%b o%b e%b, want %h z%b s%b o%b e%b",
               val_e, zf, sf, of, err, e.v, e.zf, e.sf, e.of, e.err);
    end
  endtask

  task automatic test_random;
    int cyc, bc;
    bit to;
    exp_t e;
    logic [63:0] a, b;
    logic [3:0] f;
    for (int i = 0; i < 8; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      f = 4'($urandom_range(0, 3));
      run_op(a, b, f, cyc, bc, to);
      e = sb_q.pop_front();
      checks++;
      if (to || {val_e, zf, sf, of, err} !== {e.v, e.zf, e.sf, e.of, e.err}) begin
        errors++;
        $display("FAIL random_%0d op%0d: got %h z%b s%b o%b e%b, want %h z%b s%b o%b e%b",
                 i, f, val_e, zf, sf, of, err, e.v, e.zf, e.sf, e.of, e.err);
      end
    end
  endtask

  initial begin
    test_reset;
    test_add;
    test_sub;
    test_overflow;
    test_logic;
    test_illegal;
    test_hold_start;
    test_back_to_back;
    test_reset_midrun;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
